// File: rtl/hello_checker_pkg.sv
// -----------------------------------------------------------------------------
// hello_checker_pkg
// Shared constants for the "Hello World!" generator / checker pair. The
// transmit and receive sides both import this package, so they always agree
// on the string contents and the index width.
// -----------------------------------------------------------------------------
package hello_checker_pkg;

  // Number of characters in the string and width of the position index.
  localparam int HELLO_LEN = 12;
  localparam int IDX_W     = 4;

  // Same length as an index-width value, for width-clean comparisons.
  localparam logic [IDX_W-1:0] HELLO_LEN_IDX = 4'd12;
  localparam logic [IDX_W-1:0] HELLO_LAST    = 4'd11;

  // Characters that carry special meaning for the checker.
  localparam logic [7:0] CHAR_H    = 8'd72;  // 'H' starts a string
  localparam logic [7:0] CHAR_BANG = 8'd33;  // '!' ends a string

  // "Hello World!" as ASCII codes, position 0 first.
  localparam logic [7:0] HELLO_CHARS [HELLO_LEN] = '{
    8'd72,  8'd101, 8'd108, 8'd108, 8'd111, 8'd32,
    8'd87,  8'd111, 8'd114, 8'd108, 8'd100, 8'd33
  };

  // String position type shared by generator and checker.
  typedef logic [IDX_W-1:0] hello_idx_t;

endpackage

// File: rtl/hello_rom.sv
// -----------------------------------------------------------------------------
// hello_rom
// Combinational lookup of the expected character at a string position.
// Positions beyond the end of the string return 0, a code that never appears
// in the string.
//
// Ports:
//   index  in   IDX_W  string position
//   letter out  8      ASCII code expected at that position (0 if out of range)
// -----------------------------------------------------------------------------
module hello_rom
  import hello_checker_pkg::*;
(
  input  logic [IDX_W-1:0] index,
  output logic [7:0]       letter
);

  // Table lookup with an explicit out-of-range value.
  always_comb begin
    letter = 8'd0;
    if (index < HELLO_LEN_IDX) begin
      letter = HELLO_CHARS[index];
    end else begin
      letter = 8'd0;
    end
  end

endmodule

// File: rtl/hello_checker.sv
// -----------------------------------------------------------------------------
// hello_checker
// Receive-side checker for the "Hello World!" character stream. Tracks the
// position in the string for every enabled character, pulses on a full match
// and on a mismatch in the middle of a string, and keeps saturating match and
// error counters. All outputs are registered (one-cycle latency).
//
// Ports:
//   _clock       in   1        system clock, rising edge
//   _reset       in   1        asynchronous active-low reset
//   _enable      in   1        character-valid strobe
//   _letter      in   8        ASCII character under test
//   _match       out  1        one-cycle pulse: full string matched
//   _error       out  1        one-cycle pulse: mismatch mid-string
//   _index       out  4        next expected string position
//   _locked      out  1        sticky, set by the first full match
//   _matchCount  out  COUNT_W  saturating count of full matches
//   _errorCount  out  COUNT_W  saturating count of mid-string errors
// -----------------------------------------------------------------------------
module hello_checker
  import hello_checker_pkg::*;
#(
  parameter int COUNT_W = 8,
  parameter int STR_LEN = 12
) (
  input  logic               _clock,
  input  logic               _reset,
  input  logic               _enable,
  input  logic [7:0]         _letter,
  output logic               _match,
  output logic               _error,
  output logic [IDX_W-1:0]   _index,
  output logic               _locked,
  output logic [COUNT_W-1:0] _matchCount,
  output logic [COUNT_W-1:0] _errorCount
);

  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(STR_LEN - 1);
  localparam logic [IDX_W-1:0]   IDX_ZERO = {IDX_W{1'b0}};
  localparam logic [IDX_W-1:0]   IDX_ONE  = {{(IDX_W-1){1'b0}}, 1'b1};
  localparam logic [COUNT_W-1:0] CNT_MAX  = {COUNT_W{1'b1}};
  localparam logic [COUNT_W-1:0] CNT_ZERO = {COUNT_W{1'b0}};
  localparam logic [COUNT_W-1:0] CNT_ONE  = {{(COUNT_W-1){1'b0}}, 1'b1};

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] value);
    if (value == CNT_MAX) begin
      return value;
    end else begin
      return value + CNT_ONE;
    end
  endfunction

  logic [7:0]         expected;
  logic [IDX_W-1:0]   index_next;
  logic               match_next;
  logic               error_next;
  logic               locked_next;
  logic [COUNT_W-1:0] match_count_next;
  logic [COUNT_W-1:0] error_count_next;

  hello_rom u_rom (
    .index  (_index),
    .letter (expected)
  );

  // Next-state decode: position tracking, pulses and counter updates.
  always_comb begin
    index_next       = _index;
    match_next       = 1'b0;
    error_next       = 1'b0;
    locked_next      = _locked;
    match_count_next = _matchCount;
    error_count_next = _errorCount;

    if (_enable) begin
      if (_index > LAST_IDX) begin
        // Unreachable position: recover silently to the start.
        index_next = IDX_ZERO;
      end else if (_letter == expected) begin
        if (_index == LAST_IDX) begin
          match_next       = 1'b1;
          index_next       = IDX_ZERO;
          locked_next      = 1'b1;
          match_count_next = sat_inc(_matchCount);
        end else begin
          index_next = _index + IDX_ONE;
        end
      end else begin
        // At position 0 we are just hunting for 'H'; only a broken string
        // in progress counts as an error.
        if (_index != IDX_ZERO) begin
          error_next       = 1'b1;
          error_count_next = sat_inc(_errorCount);
        end else begin
          error_next = 1'b0;
        end
        // The offending character may itself start a new string.
        if (_letter == CHAR_H) begin
          index_next = IDX_ONE;
        end else begin
          index_next = IDX_ZERO;
        end
      end
    end else begin
      index_next = _index;
    end
  end

  // Output and state registers.
  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      _index      <= IDX_ZERO;
      _match      <= 1'b0;
      _error      <= 1'b0;
      _locked     <= 1'b0;
      _matchCount <= CNT_ZERO;
      _errorCount <= CNT_ZERO;
    end else begin
      _index      <= index_next;
      _match      <= match_next;
      _error      <= error_next;
      _locked     <= locked_next;
      _matchCount <= match_count_next;
      _errorCount <= error_count_next;
    end
  end

endmodule

// File: tb/tb_hello_checker.sv
// -----------------------------------------------------------------------------
// tb_hello_checker
// Directed self-checking bench for hello_checker (counters 2 bits wide so
// saturation is reachable quickly).
// -----------------------------------------------------------------------------
module tb_hello_checker;

  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          en = 1'b0;
  logic [7:0]    letter = 8'd0;
  logic          match;
  logic          error;
  logic [3:0]    index;
  logic          locked;
  logic [CW-1:0] match_count;
  logic [CW-1:0] error_count;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] str [12] = '{8'd72, 8'd101, 8'd108, 8'd108, 8'd111, 8'd32,
                           8'd87, 8'd111, 8'd114, 8'd108, 8'd100, 8'd33};

  hello_checker #(.COUNT_W(CW), .STR_LEN(12)) dut (
    ._clock      (clk),
    ._reset      (rst_n),
    ._enable     (en),
    ._letter     (letter),
    ._match      (match),
    ._error      (error),
    ._index      (index),
    ._locked     (locked),
    ._matchCount (match_count),
    ._errorCount (error_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one character and sample outputs 1 time unit after the edge.
  task automatic step(input logic e, input logic [7:0] l);
    en = e;
    letter = l;
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_index"},  int'(index), 0);
    check({tag, "_match"},  int'(match), 0);
    check({tag, "_error"},  int'(error), 0);
    check({tag, "_locked"}, int'(locked), 0);
    check({tag, "_mcount"}, int'(match_count), 0);
    check({tag, "_ecount"}, int'(error_count), 0);
  endtask

  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  int   pulses;
  int   errs;
  logic [7:0] err_str [3] = '{8'd72, 8'd101, 8'd120};  // "Hex"

  initial begin
    // Reset held with a valid 'H' on the input.
    en = 1'b1;
    letter = 8'd72;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("rst_hold");
    rst_n = 1'b1;

    // Asynchronous reset between edges clears progress immediately.
    step(1'b1, 8'd72);
    step(1'b1, 8'd101);
    check("pre_async_index", int'(index), 2);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_index", int'(index), 0);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Clean string on consecutive cycles.
    pulses = 0;
    errs = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, str[i]);
      check($sformatf("clean_idx%0d", i), int'(index), (i + 1) % 12);
      check($sformatf("clean_match%0d", i), int'(match), (i == 11) ? 1 : 0);
      errs += int'(error);
    end
    check("clean_errors", errs, 0);
    check("clean_mcount", int'(match_count), 1);
    check("clean_locked", int'(locked), 1);
    step(1'b0, 8'd33);
    check("clean_match_drop", int'(match), 0);

    // Gapped stream: two idle cycles between characters.
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b1, str[i]);
      pulses += int'(match);
      for (int g = 0; g < 2; g++) begin
        step(1'b0, str[(i + 1) % 12]);
        check($sformatf("gap_hold%0d_%0d", i, g), int'(index), (i + 1) % 12);
        check($sformatf("gap_nomatch%0d_%0d", i, g), int'(match), 0);
      end
    end
    check("gap_pulses", pulses, 1);
    check("gap_mcount", int'(match_count), 2);

    // Mid-string error: "Hel" then 'x'.
    step(1'b1, 8'd72);
    step(1'b1, 8'd101);
    step(1'b1, 8'd108);
    check("err_pre_idx", int'(index), 3);
    step(1'b1, 8'd120);
    check("err_x_pulse", int'(error), 1);
    check("err_x_idx", int'(index), 0);
    check("err_x_ecount", int'(error_count), 1);
    step(1'b0, 8'd0);
    check("err_x_drop", int'(error), 0);
    check("err_locked_sticky", int'(locked), 1);

    // "HeH" resynchronises on the second 'H'.
    step(1'b1, 8'd72);
    step(1'b1, 8'd101);
    step(1'b1, 8'd72);
    check("heh_pulse", int'(error), 1);
    check("heh_idx", int'(index), 1);
    check("heh_ecount", int'(error_count), 2);
    pulses = 0;
    for (int i = 1; i < 12; i++) begin
      step(1'b1, str[i]);
      pulses += int'(match);
    end
    check("heh_complete_pulses", pulses, 1);
    check("heh_mcount", int'(match_count), 3);

    // Idle noise while hunting at position 0.
    errs = 0;
    for (int i = 0; i < 20; i++) begin
      step(1'b1, (i % 2 == 0) ? 8'd0 : 8'd90);
      errs += int'(error);
      check($sformatf("noise_idx%0d", i), int'(index), 0);
    end
    check("noise_errors", errs, 0);
    check("noise_ecount", int'(error_count), 2);

    // Saturation from a clean reset: 5 back-to-back strings.
    pulse_reset();
    check_all_zero("sat_rst");
    pulses = 0;
    for (int s = 0; s < 5; s++) begin
      for (int i = 0; i < 12; i++) begin
        step(1'b1, str[i]);
        pulses += int'(match);
      end
      check($sformatf("sat_mcount%0d", s), int'(match_count), (s + 1 > 3) ? 3 : s + 1);
    end
    check("sat_pulses", pulses, 5);

    // Error counter saturates but the pulse keeps firing.
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 3; i++) begin
        step(1'b1, err_str[i]);
      end
      check($sformatf("esat_pulse%0d", k), int'(error), 1);
      check($sformatf("esat_ecount%0d", k), int'(error_count), (k + 1 > 3) ? 3 : k + 1);
    end

    // Reset in the middle of "Hello" discards everything.
    for (int i = 0; i < 5; i++) begin
      step(1'b1, str[i]);
    end
    check("mid_pre_idx", int'(index), 5);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("mid_rst");
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 8'd72);
    check("post_rst_H_idx", int'(index), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
